// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit-path arbiter.
// Imported by the top-level FSM and the round-robin selector.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } arb_state_e;

  // Successor of index i in a ring of n entries.
  function automatic int unsigned wrap_next(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo N. Works for any N, not only powers of two.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int unsigned  scan;
  logic [IW-1:0] cand;

  // NOTE: every variable written here gets a default first, so no path leaves a latch.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    scan       = 0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      scan = int'(ptr) + k;
      if (scan >= N) scan = scan - N;
      cand = IW'(scan);
      if (!any && req[cand]) begin
        any             = 1'b1;
        gnt_idx         = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one batch-load UART transmit path among NREQ requesters:
// grant, latch word, pulse tx_trigger, then count tx_done rising edges (with watchdog).
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int DBITS      = 8,
  parameter  int WORD_BYTES = 4,
  parameter  int TIMEOUT    = 2**20,
  localparam int IW         = $clog2(NREQ),
  localparam int W          = DBITS * WORD_BYTES,
  localparam int BC_W       = $clog2(WORD_BYTES + 1),
  localparam int WD_W       = $clog2(TIMEOUT)
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_trigger,
  output logic [W-1:0]      tx_in,
  input  logic              tx_done,
  output logic              busy,
  output logic [IW-1:0]     grant_id,
  output logic              timeout_err
);

  arb_state_e      state;
  logic [IW-1:0]   rr_ptr;
  logic [BC_W-1:0] byte_cnt;
  logic [WD_W-1:0] wdog;
  logic            tx_done_q;
  logic            done_edge;

  logic [NREQ-1:0] gnt_onehot;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // Accept is visible in the grant cycle itself so the requester can drop valid next cycle.
  assign req_ready = (state == ST_IDLE) ? gnt_onehot : '0;
  assign done_edge = tx_done & ~tx_done_q;

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      tx_in       <= '0;
      grant_id    <= '0;
      tx_trigger  <= 1'b0;
      busy        <= 1'b0;
      byte_cnt    <= '0;
      wdog        <= '0;
      tx_done_q   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_done_q  <= tx_done;
      tx_trigger <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            tx_in      <= req_data[int'(gnt_idx)*W +: W];
            grant_id   <= gnt_idx;
            rr_ptr     <= IW'(wrap_next(int'(gnt_idx), NREQ));
            tx_trigger <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          byte_cnt <= BC_W'(WORD_BYTES);
          wdog     <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (done_edge) begin
            byte_cnt <= byte_cnt - 1'b1;
            wdog     <= '0;
            if (byte_cnt == BC_W'(1)) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            // Transmitter stalled: abandon the word, flag it until the next reset.
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=4, 4x8-bit words, TIMEOUT=64).
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk_100MHz = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_trigger;
  logic [W-1:0]      tx_in;
  logic              tx_done;
  logic              busy;
  logic [1:0]        grant_id;
  logic              timeout_err;

  logic [W-1:0] words [NREQ] = '{32'h0123_4567, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h8BAD_F00D};

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.NREQ(4), .DBITS(8), .WORD_BYTES(4), .TIMEOUT(64)) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_trigger  (tx_trigger),
    .tx_in       (tx_in),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_100MHz);
    #1;
  endtask

  // n rising edges of tx_done; returns 1 ns after the posedge that sees the last edge.
  task automatic serve_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (i < n - 1) tick();
    end
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int cycles;
    reset_n   = 1'b0;
    req_valid = '0;
    tx_done   = 1'b0;
    req_data  = {words[3], words[2], words[1], words[0]};
    #2;
    check("rst_busy", busy, 0);
    check("rst_trigger", tx_trigger, 0);
    check("rst_ready", req_ready, 0);
    check("rst_tx_in", tx_in, 0);
    check("rst_grant", grant_id, 0);
    check("rst_terr", timeout_err, 0);
    #1 reset_n = 1'b1;
    tick();

    // Single requester
    req_valid = 4'b0010;
    #1 check("t1_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    #1;
    check("t1_ready_pulse", req_ready, 0);
    check("t1_trigger", tx_trigger, 1);
    check("t1_busy", busy, 1);
    check("t1_grant", grant_id, 1);
    check("t1_tx_in", tx_in, 32'hDEAD_BEEF);
    tick();
    check("t1_trigger_1cyc", tx_trigger, 0);
    serve_bytes(3);
    check("t1_busy_3bytes", busy, 1);
    tick();
    serve_bytes(1);
    check("t1_busy_done", busy, 0);
    tick();
    check("t1_tx_in_kept", tx_in, 32'hDEAD_BEEF);

    // Contention from a fresh pointer
    do_reset();
    req_valid = 4'b1111;
    for (int w = 0; w < NREQ; w++) begin
      #1 check("t2_ready", req_ready, 4'b0001 << w);
      tick();
      check("t2_grant", grant_id, w);
      check("t2_tx_in", tx_in, words[w]);
      check("t2_trigger", tx_trigger, 1);
      req_valid[w] = 1'b0;
      tick();
      serve_bytes(4);
      check("t2_idle", busy, 0);
    end

    // Level tx_done: one decrement per high period
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    for (int b = 0; b < 4; b++) begin
      tx_done = 1'b1;
      repeat (20) tick();
      tx_done = 1'b0;
      repeat (3) tick();
      if (b == 2) check("t3_busy_3bytes", busy, 1);
    end
    check("t3_idle", busy, 0);
    check("t3_no_regrant", req_ready, 0);

    // Request withdrawn before the grant edge
    req_valid = 4'b0010;
    #2 req_valid = '0;
    tick();
    check("t6_lost_req", busy, 0);
    check("t6_lost_grant", grant_id, 0);

    // Spurious edges in IDLE and LOAD
    serve_bytes(2);
    tick();
    check("t6_idle_edges", busy, 0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tx_done   = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    serve_bytes(3);
    check("t6_busy_3fresh", busy, 1);
    tick();
    serve_bytes(1);
    check("t6_done", busy, 0);
    check("t6_grant", grant_id, 2);

    // Watchdog
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    check("t4_terr_pre", timeout_err, 0);
    tick();
    serve_bytes(2);
    cycles = 0;
    while (busy && cycles < 200) begin
      tick();
      cycles++;
    end
    check("t4_wdog_cycles", cycles, 64);
    check("t4_terr", timeout_err, 1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    serve_bytes(4);
    check("t4_terr_sticky", timeout_err, 1);
    check("t4_idle", busy, 0);
    do_reset();
    check("t4_terr_reset", timeout_err, 0);

    // Reset mid-SEND
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    serve_bytes(1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_trigger", tx_trigger, 0);
    check("t5_tx_in", tx_in, 0);
    #2 reset_n = 1'b1;
    tick();
    req_valid = 4'b1111;
    #1 check("t5_ptr_zero", req_ready, 4'b0001);
    req_valid = 4'b1000;
    #1 check("t5_ready3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    check("t5_grant3", grant_id, 3);
    check("t5_tx_in3", tx_in, 32'h8BAD_F00D);
    tick();
    serve_bytes(4);
    check("t5_done", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
